uart_tx_arbiter: RTL and testbench

- Shares one UART_TX transmitter between NUM_REQ byte producers, such as a debug console, status reporter and error logger.
- Arbitrates round-robin and latches the winning byte.
- Drives the transmitter's data_in/data_ready one-cycle launch pulse, then tracks TX_busy until the frame completes.
- Supports burst lock: a requester holds the grant until it marks its last byte.

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX between NUM_REQ byte producers.
// Round-robin grant (fixed priority with UART_ARB_FIXED_PRIO_EN), burst lock, start timeout.
// Ports: clk, rst_n; req_valid/req_data/req_last in, req_ready out (one-hot);
//   tx_data_in/tx_data_ready out, tx_busy in; grant_valid/grant_id/timeout_err out.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data_in,
  output logic                 tx_data_ready,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  logic [7:0]       data_arr [NUM_REQ];
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest valid index is the last writer.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(i);
      end
    end
`else
    // First valid index after the last owner, wrapping.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found &&
          req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    tx_data_d     = tx_data_q;
    lock_d        = lock_q;
    cnt_d         = cnt_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    req_ready     = '0;
    tx_data_ready = 1'b0;
    timeout_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A frame still on the wire blocks a new grant.
        if (!tx_busy && pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        req_ready[grant_id_q] = 1'b1;
        tx_data_d = data_arr[grant_id_q];
        lock_d    = ~req_last[grant_id_q];
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d  = grant_id_q;
`endif
        state_d   = S_LAUNCH;
      end
      S_LAUNCH: begin
        tx_data_ready = 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          timeout_err   = 1'b1;
          lock_d        = 1'b0;
          grant_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_q) begin
            state_d = S_HOLD;
          end else begin
            grant_valid_d = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (req_valid[grant_id_q]) begin
          state_d = S_GRANT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      tx_data_q     <= '0;
      lock_q        <= 1'b0;
      cnt_q         <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      tx_data_q     <= tx_data_d;
      lock_q        <= lock_d;
      cnt_q         <= cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign tx_data_in  = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Requester queues drive the DUT; a monitor checks each launch in order.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int FRAME = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data_in;
  logic           tx_data_ready;
  logic           tx_busy;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           timeout_err;
  logic           tx_en = 1'b1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t       sb [$];
  logic [8:0] rq [N][$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data_in(tx_data_in),
    .tx_data_ready(tx_data_ready),
    .tx_busy(tx_busy),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_tx(input logic [1:0] id, input logic [7:0] d);
    sb.push_back({id, d});
  endtask

  task automatic wait_cond(input int which, input int budget,
                           input string name, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = |req_ready;
        1: hit = tx_data_ready;
        2: hit = tx_busy;
        3: hit = !tx_busy;
        4: hit = timeout_err;
        5: hit = grant_valid;
        6: hit = (sb.size() == 0);
        default: hit = !grant_valid;
      endcase
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_%s actual=expired required=event within %0d cycles",
               name, budget);
    end
  endtask

  task automatic settle();
    int n;
    wait_cond(6, 3000, "sb_drain", n);
    wait_cond(3, 300, "busy_low", n);
    wait_cond(7, 50, "grant_drop", n);
    @(negedge clk);
  endtask

  // UART_TX stand-in: busy one cycle after launch, for one frame.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_data_ready && tx_en) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Requester driver: head of each queue is presented until accepted.
  always begin
    logic [N-1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i] = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      req_last[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
  end

  // Monitor: every launch must match the next expected byte/owner.
  always @(negedge clk) begin
    if (rst_n && tx_data_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL launch_unexpected actual=id%0d/0x%0h required=none",
                 grant_id, tx_data_in);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("launch_id", 32'(grant_id), 32'(e.id));
        chk("launch_data", 32'(tx_data_in), 32'(e.d));
      end
    end
    if (rst_n && req_ready != '0) begin
      chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
    end
  end

  initial begin
    int n;
    bit bad;
    bit busy_seen;

    repeat (2) @(negedge clk);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_ready", 32'(tx_data_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data_in), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all four valid
    push(0, 8'h10, 1'b1);
    push(0, 8'h10, 1'b1);
    push(1, 8'h21, 1'b1);
    push(2, 8'h32, 1'b1);
    push(3, 8'h43, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
    expect_tx(2'd0, 8'h10);
    expect_tx(2'd0, 8'h10);
    expect_tx(2'd1, 8'h21);
    expect_tx(2'd2, 8'h32);
    expect_tx(2'd3, 8'h43);
`else
    expect_tx(2'd0, 8'h10);
    expect_tx(2'd1, 8'h21);
    expect_tx(2'd2, 8'h32);
    expect_tx(2'd3, 8'h43);
    expect_tx(2'd0, 8'h10);
`endif
    settle();

    // Single byte latency
    push(0, 8'hAA, 1'b1);
    expect_tx(2'd0, 8'hAA);
    @(negedge clk);
    chk("single_no_early_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0001);
    chk("single_gv_up", 32'(grant_valid), 32'd1);
    @(negedge clk);
    chk("single_launch", 32'(tx_data_ready), 32'd1);
    chk("single_ready_pulse", 32'(req_ready), 32'd0);
    chk("single_data", 32'(tx_data_in), 32'hAA);
    @(negedge clk);
    chk("single_launch_pulse", 32'(tx_data_ready), 32'd0);
    wait_cond(2, 10, "single_busy_hi", n);
    wait_cond(3, 200, "single_busy_lo", n);
    chk("single_gv_hold", 32'(grant_valid), 32'd1);
    chk("single_data_hold", 32'(tx_data_in), 32'hAA);
    @(negedge clk);
    chk("single_gv_fall", 32'(grant_valid), 32'd0);
    settle();

    // Burst lock: requester 2 holds the grant over requester 1
    push(2, 8'h01, 1'b0);
    push(2, 8'h02, 1'b0);
    push(2, 8'h03, 1'b1);
    expect_tx(2'd2, 8'h01);
    expect_tx(2'd2, 8'h02);
    expect_tx(2'd2, 8'h03);
    expect_tx(2'd1, 8'h77);
    wait_cond(5, 10, "burst_grant", n);
    chk("burst_first_owner", 32'(grant_id), 32'd2);
    push(1, 8'h77, 1'b1);
    settle();

    // Start timeout with no busy response
    tx_en = 1'b0;
    push(0, 8'h55, 1'b1);
    expect_tx(2'd0, 8'h55);
    wait_cond(1, 10, "to_launch", n);
    wait_cond(4, 40, "to_pulse", n);
    chk("timeout_latency", 32'(n), 32'd16);
    chk("timeout_gv_at_pulse", 32'(grant_valid), 32'd1);
    @(negedge clk);
    chk("timeout_pulse_width", 32'(timeout_err), 32'd0);
    chk("timeout_gv_drop", 32'(grant_valid), 32'd0);
    tx_en = 1'b1;
    settle();

    // Reset in the middle of a frame
    push(0, 8'h9C, 1'b1);
    expect_tx(2'd0, 8'h9C);
    wait_cond(2, 20, "rst_busy_hi", n);
    repeat (3) @(negedge clk);
    chk("rst_pre_gv", 32'(grant_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_gv", 32'(grant_valid), 32'd0);
    chk("rstmid_data", 32'(tx_data_in), 32'd0);
    chk("rstmid_id", 32'(grant_id), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    chk("rstmid_launch", 32'(tx_data_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 8'h5A, 1'b1);
    expect_tx(2'd0, 8'h5A);
    bad = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!tx_busy) break;
      busy_seen = 1'b1;
      if (grant_valid || req_ready != '0) bad = 1'b1;
    end
    chk("rst_busy_after_release", 32'(busy_seen), 32'd1);
    chk("rst_no_grant_while_busy", 32'(bad), 32'd0);
    settle();

    // Two requesters held: round-robin alternates, fixed priority starves 2
    push(1, 8'hB1, 1'b1);
    push(1, 8'hB2, 1'b1);
    push(1, 8'hB3, 1'b1);
    push(2, 8'hC2, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
    expect_tx(2'd1, 8'hB1);
    expect_tx(2'd1, 8'hB2);
    expect_tx(2'd1, 8'hB3);
    expect_tx(2'd2, 8'hC2);
`else
    expect_tx(2'd1, 8'hB1);
    expect_tx(2'd2, 8'hC2);
    expect_tx(2'd1, 8'hB2);
    expect_tx(2'd1, 8'hB3);
`endif
    settle();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
